alu_serial_ctrl: RTL

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer driving an external 1-bit ALU slice.
// One operand bit is processed per clock, LSB first, over WIDTH cycles.
// Optional feature macro: ALU_SERIAL_SLT_EN enables the set-less-than opcode (0111).
module alu_serial_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       alu_ctrl_i,
   output logic             bit_src1_o,
   output logic             bit_src2_o,
   output logic             ainvert_o,
   output logic             binvert_o,
   output logic             cin_o,
   output logic [1:0]       operation_o,
   input  logic             bit_result_i,
   input  logic             bit_cout_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o
);

   localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SERIAL_SLT_EN
   localparam logic [3:0] OP_SLT = 4'b0111;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] src1_q, src2_q, shift_q;
   logic [3:0]       op_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic             done_q;

   // decoded opcode controls
   logic             is_valid, is_addsub, is_slt, sub_mode;
   logic             ainv, binv;
   logic [1:0]       oper;

   // completion values presented on the last RUN edge
   logic [WIDTH-1:0] final_vec, final_result;
   logic             final_cout, final_ovf, msb_ovf;

   // Decode the captured opcode into slice controls.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      is_valid  = 1'b0;
      is_addsub = 1'b0;
      is_slt    = 1'b0;
      sub_mode  = 1'b0;
      ainv      = 1'b0;
      binv      = 1'b0;
      oper      = 2'd0;
      case (op_q)
         OP_AND: is_valid = 1'b1;
         OP_OR: begin
            is_valid = 1'b1;
            oper     = 2'd1;
         end
         OP_ADD: begin
            is_valid  = 1'b1;
            is_addsub = 1'b1;
            oper      = 2'd2;
         end
         OP_SUB: begin
            is_valid  = 1'b1;
            is_addsub = 1'b1;
            sub_mode  = 1'b1;
            binv      = 1'b1;
            oper      = 2'd2;
         end
         OP_NOR: begin
            is_valid = 1'b1;
            ainv     = 1'b1;
            binv     = 1'b1;
         end
`ifdef ALU_SERIAL_SLT_EN
         OP_SLT: begin
            is_valid = 1'b1;
            is_slt   = 1'b1;
            sub_mode = 1'b1;
            binv     = 1'b1;
            oper     = 2'd2;
         end
`endif
         default: ;
      endcase
   end

   // Drive the slice from the registered operands; quiet outside RUN and for unsupported opcodes.
   always_comb begin
      bit_src1_o  = 1'b0;
      bit_src2_o  = 1'b0;
      ainvert_o   = 1'b0;
      binvert_o   = 1'b0;
      cin_o       = 1'b0;
      operation_o = 2'd0;
      if (state_q == S_RUN && is_valid) begin
         bit_src1_o  = src1_q[idx_q];
         bit_src2_o  = src2_q[idx_q];
         ainvert_o   = ainv;
         binvert_o   = binv;
         operation_o = oper;
         cin_o       = (idx_q == '0) ? sub_mode : carry_q;
      end
   end

   // Assemble the final result and flags from the shift register plus the live MSB slice output.
   always_comb begin
      final_vec            = shift_q;
      final_vec[WIDTH-1]   = bit_result_i;
      msb_ovf              = cin_o ^ bit_cout_i;
      final_result         = '0;
      final_cout           = 1'b0;
      final_ovf            = 1'b0;
      if (is_valid) begin
         if (is_slt) begin
            final_result[0] = final_vec[WIDTH-1] ^ msb_ovf;
         end else begin
            final_result = final_vec;
            if (is_addsub) begin
               final_cout = bit_cout_i;
               final_ovf  = msb_ovf;
            end
         end
      end
   end

   // Next-state logic: one pass through RUN per accepted start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register and registered completion pulse (high the cycle after DONE).
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == S_DONE);
      end
   end

   // Operand capture, serial bit collection and result/flag update.
   // NOTE: the result shift register is plain flops, so it is reset along with everything else.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         src1_q     <= '0;
         src2_q     <= '0;
         op_q       <= '0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         shift_q    <= '0;
         result_o   <= '0;
         zero_o     <= 1'b0;
         cout_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else if (state_q == S_IDLE && start_i) begin
         src1_q  <= src1_i;
         src2_q  <= src2_i;
         op_q    <= alu_ctrl_i;
         idx_q   <= '0;
         carry_q <= 1'b0;
         shift_q <= '0;
      end else if (state_q == S_RUN) begin
         shift_q[idx_q] <= bit_result_i;
         carry_q        <= bit_cout_i;
         idx_q          <= idx_q + 1'b1;
         if (idx_q == LAST_IDX) begin
            result_o   <= final_result;
            zero_o     <= (final_result == '0);
            cout_o     <= final_cout;
            overflow_o <= final_ovf;
         end
      end
   end

   assign busy_o = (state_q == S_RUN);
   assign done_o = done_q;

endmodule
